id_ex_hazard_stage: RTL

- ID/EX pipeline register combined with a load-use/branch hazard controller for the 5-stage MIPS datapath.
- Captures decoded operands and control from ID, and inserts bubbles when an operand is not yet available.
- Gates PC and IF/ID writes during a stall.
- Its registered rs/rt and write-register outputs feed the EX-stage forwarding logic and, one stage later, the EX/MEM register.

---
 rtl/id_ex_hazard_stage_if.sv | 42 ++++
 rtl/id_ex_hazard_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bus: decoded ID-side operands/control in, registered EX-side fields and hazard controls out.
// Ports: master drives ID-stage fields, MEM-stage load info and Flush; slave (the stage) returns EX fields and PC/IF-ID gating.
// DW/CNTW must match the parameters of the id_ex_hazard_stage instance that uses it.
interface id_ex_hazard_stage_if #(
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    // ID-stage inputs
    logic [4:0]      rs_ID, rt_ID, rd_ID;
    logic            UsesRt_ID, Branch_ID;
    logic            RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID;
    logic [3:0]      ALUOp_ID;
    logic [DW-1:0]   ReadData1_ID, ReadData2_ID, Imm_ID;
    logic            MemRead_EX_MEM;
    logic [4:0]      rd_EX_MEM;
    logic            Flush;
    // EX-stage outputs
    logic [4:0]      rs_EX, rt_EX, rd_EX, WriteReg_EX;
    logic            RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX;
    logic [3:0]      ALUOp_EX;
    logic [DW-1:0]   ReadData1_EX, ReadData2_EX, Imm_EX;
    logic            PCWrite, IFIDWrite, Stall;
    logic [CNTW-1:0] StallCount;

    modport master (
        output rs_ID, rt_ID, rd_ID, UsesRt_ID, Branch_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID,
               ALUOp_ID, ReadData1_ID, ReadData2_ID, Imm_ID, MemRead_EX_MEM, rd_EX_MEM, Flush,
        input  rs_EX, rt_EX, rd_EX, WriteReg_EX,
               RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX,
               ALUOp_EX, ReadData1_EX, ReadData2_EX, Imm_EX, PCWrite, IFIDWrite, Stall, StallCount
    );

    modport slave (
        input  rs_ID, rt_ID, rd_ID, UsesRt_ID, Branch_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID,
               ALUOp_ID, ReadData1_ID, ReadData2_ID, Imm_ID, MemRead_EX_MEM, rd_EX_MEM, Flush,
        output rs_EX, rt_EX, rd_EX, WriteReg_EX,
               RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX,
               ALUOp_EX, ReadData1_EX, ReadData2_EX, Imm_EX, PCWrite, IFIDWrite, Stall, StallCount
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch hazard control and a saturating stall counter.
// Latency: ID fields appear on EX outputs one edge after capture; Stall/PCWrite/IFIDWrite are combinational.
// Backpressure: Stall holds PC and IF/ID (PCWrite=IFIDWrite=0) and loads a bubble; Flush overrides everything.
// Ports: Clk, Reset (sync, active-high) plus the slave side of id_ex_hazard_stage_if.
module id_ex_hazard_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    id_ex_hazard_stage_if.slave   bus
);
    typedef struct packed {
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic          reg_dst;
        logic [3:0]    alu_op;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
    } idex_t;

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state_q, state_d;
    idex_t           idex_q, idex_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [4:0]      write_reg_ex;
    logic            lu, b1, bm, b2;
    logic            stall;

    // $0 never matches, so it can never create a hazard.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign write_reg_ex = idex_q.reg_dst ? idex_q.rd : idex_q.rt;

    always_comb begin
        lu = 1'b0;
        b1 = 1'b0;
        bm = 1'b0;
        b2 = 1'b0;
        if (state_q == RUN) begin
            lu = idex_q.mem_read &&
                 reg_match(write_reg_ex, bus.rs_ID, bus.rt_ID, bus.UsesRt_ID);
            b1 = bus.Branch_ID && idex_q.reg_write && !idex_q.mem_read &&
                 reg_match(write_reg_ex, bus.rs_ID, bus.rt_ID, bus.UsesRt_ID);
            bm = bus.Branch_ID && bus.MemRead_EX_MEM &&
                 reg_match(bus.rd_EX_MEM, bus.rs_ID, bus.rt_ID, bus.UsesRt_ID);
            b2 = bus.Branch_ID && idex_q.mem_read &&
                 reg_match(write_reg_ex, bus.rs_ID, bus.rt_ID, bus.UsesRt_ID);
        end
    end

    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        if (bus.Flush) begin
            stall   = 1'b0;
            state_d = RUN;
        end else if (state_q == HOLD) begin
            // Second bubble of a branch-after-load: no re-evaluation.
            stall   = 1'b1;
            state_d = RUN;
        end else if (b2) begin
            stall   = 1'b1;
            state_d = HOLD;
        end else if (lu || b1 || bm) begin
            stall   = 1'b1;
            state_d = RUN;
        end

        idex_d.rs         = bus.rs_ID;
        idex_d.rt         = bus.rt_ID;
        idex_d.rd         = bus.rd_ID;
        idex_d.reg_write  = bus.RegWrite_ID;
        idex_d.mem_read   = bus.MemRead_ID;
        idex_d.mem_write  = bus.MemWrite_ID;
        idex_d.mem_to_reg = bus.MemToReg_ID;
        idex_d.alu_src    = bus.ALUSrc_ID;
        idex_d.reg_dst    = bus.RegDst_ID;
        idex_d.alu_op     = bus.ALUOp_ID;
        idex_d.rd1        = bus.ReadData1_ID;
        idex_d.rd2        = bus.ReadData2_ID;
        idex_d.imm        = bus.Imm_ID;
        // Bubbles clear register fields too, so forwarding sees $0.
        if (bus.Flush || stall) begin
            idex_d = '0;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            idex_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
            cnt_q   <= cnt_d;
        end
    end

    // The reset cycle always reports a free-running pipe.
    assign bus.Stall        = stall && !Reset;
    assign bus.PCWrite      = !bus.Stall;
    assign bus.IFIDWrite    = !bus.Stall;
    assign bus.StallCount   = cnt_q;
    assign bus.WriteReg_EX  = write_reg_ex;
    assign bus.rs_EX        = idex_q.rs;
    assign bus.rt_EX        = idex_q.rt;
    assign bus.rd_EX        = idex_q.rd;
    assign bus.RegWrite_EX  = idex_q.reg_write;
    assign bus.MemRead_EX   = idex_q.mem_read;
    assign bus.MemWrite_EX  = idex_q.mem_write;
    assign bus.MemToReg_EX  = idex_q.mem_to_reg;
    assign bus.ALUSrc_EX    = idex_q.alu_src;
    assign bus.ALUOp_EX     = idex_q.alu_op;
    assign bus.ReadData1_EX = idex_q.rd1;
    assign bus.ReadData2_EX = idex_q.rd2;
    assign bus.Imm_EX       = idex_q.imm;
endmodule
